// File: rtl/vga_sprite_memory_arbiter.sv
// vga_sprite_memory_arbiter
// Shares one synchronous single-port sprite RAM between the display fetch
// path, a sprite loader and a clear engine. The display always wins, then
// the clear engine, then the loader. All RAM pins are driven from registers.
module vga_sprite_memory_arbiter #(
    parameter int N    = 8,
    parameter int Size = 16,
    parameter int W    = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    // display fetch path
    input  logic         Disp_Req,
    input  logic [9:0]   Disp_Row,
    input  logic [9:0]   Disp_Col,
    output logic         Disp_Valid,
    output logic [W-1:0] Disp_Data,
    // sprite loader
    input  logic         Load_Valid,
    output logic         Load_Ready,
    input  logic [9:0]   Load_Row,
    input  logic [9:0]   Load_Col,
    input  logic [W-1:0] Load_Data,
    // clear engine
    input  logic         Clear_Start,
    output logic         Busy,
    output logic         Clear_Done,
    // sprite RAM pins
    output logic [N-1:0] Mem_Address,
    output logic         Mem_WE,
    output logic [W-1:0] Mem_WData,
    input  logic [W-1:0] Mem_RData
);

    // Last linear address of the sprite; the clear ends after writing it.
    localparam logic [31:0] LAST_ADDR = 32'(Size * Size - 1);
    localparam logic [N:0]  CNT_ONE   = 1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t         state_reg;
    logic [N:0]     count_reg;
    logic [N-1:0]   mem_address_reg;
    logic           mem_we_reg;
    logic [W-1:0]   mem_wdata_reg;
    logic           busy_reg;
    logic           clear_done_reg;

    // display read pipeline: stage a follows the address edge, stage b the RAM edge
    logic           rd_req_a_reg;
    logic           rd_hit_a_reg;
    logic           rd_req_b_reg;
    logic           rd_hit_b_reg;
    logic           disp_valid_reg;
    logic [W-1:0]   disp_data_reg;

    logic           disp_in_range;
    logic           load_in_range;
    logic           disp_hit;
    logic           load_fire;
    logic           load_write;
    logic           clear_write;
    logic           clear_last;
    logic [N-1:0]   disp_addr;
    logic [N-1:0]   load_addr;

    // Linear address at full width, truncated to the RAM address width.
    function automatic logic [N-1:0] lin_addr(input logic [9:0] row, input logic [9:0] col);
        logic [31:0] full;
        full = 32'(row) * 32'(Size) + 32'(col);
        return full[N-1:0];
    endfunction

    function automatic logic in_range(input logic [9:0] row, input logic [9:0] col);
        return (32'(row) < 32'(Size)) && (32'(col) < 32'(Size));
    endfunction

    assign disp_in_range = in_range(Disp_Row, Disp_Col);
    assign load_in_range = in_range(Load_Row, Load_Col);
    assign disp_addr     = lin_addr(Disp_Row, Disp_Col);
    assign load_addr     = lin_addr(Load_Row, Load_Col);

    // The loader only gets the slot when idle and the display is quiet.
    assign Load_Ready  = Reset_n & ~Disp_Req & (state_reg == ST_IDLE);

    // Grant decode; the three access kinds are mutually exclusive by construction.
    always_comb begin
        disp_hit    = Disp_Req & disp_in_range;
        load_fire   = Load_Valid & Load_Ready;
        load_write  = load_fire & load_in_range;
        clear_write = (state_reg == ST_CLEAR) & ~Disp_Req;
        clear_last  = clear_write & (count_reg == LAST_ADDR[N:0]);
    end

    // Sequencer: clear FSM, counter and registered RAM pins.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            mem_address_reg <= '0;
            mem_we_reg      <= 1'b0;
            mem_wdata_reg   <= '0;
            busy_reg        <= 1'b0;
            clear_done_reg  <= 1'b0;
        end else begin
            mem_we_reg     <= 1'b0;
            clear_done_reg <= 1'b0;

            // An out-of-range display request leaves the address pins untouched.
            if (disp_hit) begin
                mem_address_reg <= disp_addr;
            end else if (clear_write) begin
                mem_address_reg <= count_reg[N-1:0];
                mem_we_reg      <= 1'b1;
                mem_wdata_reg   <= '0;
            end else if (load_write) begin
                mem_address_reg <= load_addr;
                mem_we_reg      <= 1'b1;
                mem_wdata_reg   <= Load_Data;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (Clear_Start) begin
                        state_reg <= ST_CLEAR;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clear_write) begin
                        count_reg <= count_reg + CNT_ONE;
                        if (clear_last) begin
                            state_reg      <= ST_IDLE;
                            busy_reg       <= 1'b0;
                            clear_done_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Display return pipeline: blanks out-of-range pixels to transparent.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rd_req_a_reg   <= 1'b0;
            rd_hit_a_reg   <= 1'b0;
            rd_req_b_reg   <= 1'b0;
            rd_hit_b_reg   <= 1'b0;
            disp_valid_reg <= 1'b0;
            disp_data_reg  <= '0;
        end else begin
            rd_req_a_reg   <= Disp_Req;
            rd_hit_a_reg   <= disp_hit;
            rd_req_b_reg   <= rd_req_a_reg;
            rd_hit_b_reg   <= rd_hit_a_reg;
            disp_valid_reg <= rd_req_b_reg;
            disp_data_reg  <= rd_hit_b_reg ? Mem_RData : '0;
        end
    end

    assign Mem_Address = mem_address_reg;
    assign Mem_WE      = mem_we_reg;
    assign Mem_WData   = mem_wdata_reg;
    assign Busy        = busy_reg;
    assign Clear_Done  = clear_done_reg;
    assign Disp_Valid  = disp_valid_reg;
    assign Disp_Data   = disp_data_reg;

endmodule

// File: tb/tb_vga_sprite_memory_arbiter.sv
// Directed bench for vga_sprite_memory_arbiter with a behavioural sync RAM.
module tb_vga_sprite_memory_arbiter;

    localparam int N    = 8;
    localparam int SIZE = 16;
    localparam int W    = 8;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Disp_Req;
    logic [9:0]   Disp_Row;
    logic [9:0]   Disp_Col;
    logic         Disp_Valid;
    logic [W-1:0] Disp_Data;
    logic         Load_Valid;
    logic         Load_Ready;
    logic [9:0]   Load_Row;
    logic [9:0]   Load_Col;
    logic [W-1:0] Load_Data;
    logic         Clear_Start;
    logic         Busy;
    logic         Clear_Done;
    logic [N-1:0] Mem_Address;
    logic         Mem_WE;
    logic [W-1:0] Mem_WData;
    logic [W-1:0] Mem_RData;

    int total = 0;
    int bad   = 0;

    logic       preload;
    logic [7:0] ram [256];
    int         wr_count = 0;
    logic       clr_mon;
    int         clr_idx = 0;
    int         clr_err = 0;

    logic       v;
    logic [7:0] d;
    int         wr_before;
    int         busy_cycles;
    int         done_pulses;
    int         ready_err;
    int         found;
    int         armed;

    vga_sprite_memory_arbiter #(.N(N), .Size(SIZE), .W(W)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Disp_Req    (Disp_Req),
        .Disp_Row    (Disp_Row),
        .Disp_Col    (Disp_Col),
        .Disp_Valid  (Disp_Valid),
        .Disp_Data   (Disp_Data),
        .Load_Valid  (Load_Valid),
        .Load_Ready  (Load_Ready),
        .Load_Row    (Load_Row),
        .Load_Col    (Load_Col),
        .Load_Data   (Load_Data),
        .Clear_Start (Clear_Start),
        .Busy        (Busy),
        .Clear_Done  (Clear_Done),
        .Mem_Address (Mem_Address),
        .Mem_WE      (Mem_WE),
        .Mem_WData   (Mem_WData),
        .Mem_RData   (Mem_RData)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // Synchronous single-port RAM, read-before-write, with a preload pattern.
    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(8'(i));
        end else if (Mem_WE) begin
            ram[Mem_Address] <= Mem_WData;
        end
        Mem_RData <= ram[Mem_Address];
    end

    // Write counter and in-order clear write monitor.
    always @(posedge Clk) begin
        if (Mem_WE) begin
            wr_count <= wr_count + 1;
            if (clr_mon) begin
                if (32'(Mem_Address) != (clr_idx & 255) || Mem_WData != 8'h00)
                    clr_err <= clr_err + 1;
                clr_idx <= clr_idx + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One display read; returns what appears three edges after the request.
    task automatic disp_read(input logic [9:0] r, input logic [9:0] c,
                             output logic vo, output logic [7:0] dout);
        @(negedge Clk);
        Disp_Req = 1'b1; Disp_Row = r; Disp_Col = c;
        @(negedge Clk);
        Disp_Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        vo   = Disp_Valid;
        dout = Disp_Data;
        $display("disp read (%0d,%0d) valid=%0b data=0x%02h", r, c, vo, dout);
    endtask

    function automatic logic is_steal(input int j);
        case (j)
            3, 4, 10, 40, 41, 42, 100, 150, 200, 250: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        Reset_n = 1'b0; preload = 1'b1; clr_mon = 1'b0;
        Disp_Req = 1'b0; Disp_Row = '0; Disp_Col = '0;
        Load_Valid = 1'b0; Load_Row = '0; Load_Col = '0; Load_Data = '0;
        Clear_Start = 1'b0;
        repeat (3) @(negedge Clk);

        // reset state
        chk("rst_addr",  32'(Mem_Address), 32'd0);
        chk("rst_we",    32'(Mem_WE),      32'd0);
        chk("rst_wdata", 32'(Mem_WData),   32'd0);
        chk("rst_dval",  32'(Disp_Valid),  32'd0);
        chk("rst_ddata", 32'(Disp_Data),   32'd0);
        chk("rst_busy",  32'(Busy),        32'd0);
        chk("rst_done",  32'(Clear_Done),  32'd0);
        chk("rst_ready", 32'(Load_Ready),  32'd0);
        Reset_n = 1'b1; preload = 1'b0;

        // streamed display reads of column 5, rows 0..15
        for (int k = 0; k <= 20; k++) begin
            @(negedge Clk);
            if (k >= 1 && k <= 16) chk("stream_addr", 32'(Mem_Address), 32'((k - 1) * 16 + 5));
            chk("stream_valid", 32'(Disp_Valid), 32'(k >= 3 && k <= 18));
            if (k >= 3 && k <= 18) begin
                chk("stream_data", 32'(Disp_Data), 32'(pat(8'((k - 3) * 16 + 5))));
                $display("stream pixel row=%0d data=0x%02h", k - 3, Disp_Data);
            end
            if (k < 16) begin
                Disp_Req = 1'b1; Disp_Row = 10'(k); Disp_Col = 10'd5;
            end else begin
                Disp_Req = 1'b0;
            end
        end

        // loader write (2,3) = 0xA5
        @(negedge Clk);
        Load_Valid = 1'b1; Load_Row = 10'd2; Load_Col = 10'd3; Load_Data = 8'hA5;
        #1 chk("load_ready", 32'(Load_Ready), 32'd1);
        @(negedge Clk);
        Load_Valid = 1'b0;
        chk("load_we",    32'(Mem_WE),      32'd1);
        chk("load_addr",  32'(Mem_Address), 32'd35);
        chk("load_wdata", 32'(Mem_WData),   32'hA5);
        $display("load (2,3) addr=%0d data=0x%02h", Mem_Address, Mem_WData);
        @(negedge Clk);
        chk("load_we_once", 32'(Mem_WE), 32'd0);
        disp_read(10'd2, 10'd3, v, d);
        chk("readback_valid", 32'(v), 32'd1);
        chk("readback_data",  32'(d), 32'hA5);

        // loader held off by the display for four cycles
        wr_before = wr_count;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            Disp_Req = 1'b1; Disp_Row = 10'd0; Disp_Col = 10'd0;
            Load_Valid = 1'b1; Load_Row = 10'd4; Load_Col = 10'd1; Load_Data = 8'h3C;
            #1 chk("stall_ready", 32'(Load_Ready), 32'd0);
        end
        @(negedge Clk);
        Disp_Req = 1'b0;
        chk("stall_no_we", 32'(Mem_WE), 32'd0);
        chk("stall_no_wr", 32'(wr_count), 32'(wr_before));
        #1 chk("stall_ready_rise", 32'(Load_Ready), 32'd1);
        @(negedge Clk);
        Load_Valid = 1'b0;
        chk("stall_we",    32'(Mem_WE),      32'd1);
        chk("stall_addr",  32'(Mem_Address), 32'd65);
        chk("stall_wdata", 32'(Mem_WData),   32'h3C);
        $display("load (4,1) after stall addr=%0d data=0x%02h", Mem_Address, Mem_WData);
        @(negedge Clk);
        chk("stall_wr_count", 32'(wr_count), 32'(wr_before + 1));

        // out-of-range display and loader
        disp_read(10'd16, 10'd0, v, d);
        chk("oor_disp_valid", 32'(v), 32'd1);
        chk("oor_disp_data",  32'(d), 32'd0);
        chk("oor_disp_addr",  32'(Mem_Address), 32'd65);
        @(negedge Clk);
        wr_before = wr_count;
        Load_Valid = 1'b1; Load_Row = 10'd0; Load_Col = 10'd20; Load_Data = 8'hEE;
        #1 chk("oor_load_ready", 32'(Load_Ready), 32'd1);
        @(negedge Clk);
        Load_Valid = 1'b0;
        chk("oor_load_we", 32'(Mem_WE), 32'd0);
        @(negedge Clk);
        chk("oor_load_wr",   32'(wr_count),    32'(wr_before));
        chk("oor_load_addr", 32'(Mem_Address), 32'd65);
        $display("load (0,20) dropped, writes=%0d", wr_count - wr_before);

        // full clear with ten stolen display cycles and a stray Clear_Start
        clr_mon = 1'b1;
        busy_cycles = 0; done_pulses = 0; ready_err = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge Clk);
            if (Busy) busy_cycles++;
            if (Clear_Done) done_pulses++;
            Clear_Start = (j == 0 || j == 128);
            Disp_Req = is_steal(j);
            Disp_Row = 10'd1; Disp_Col = 10'd1;
            #1;
            if (Busy && Load_Ready) ready_err++;
        end
        Clear_Start = 1'b0; Disp_Req = 1'b0;
        clr_mon = 1'b0;
        $display("clear writes=%0d busy=%0d done=%0d", clr_idx, busy_cycles, done_pulses);
        chk("clr_busy_cycles", 32'(busy_cycles), 32'd266);
        chk("clr_done_pulses", 32'(done_pulses), 32'd1);
        chk("clr_writes",      32'(clr_idx),     32'd256);
        chk("clr_order",       32'(clr_err),     32'd0);
        chk("clr_ready_low",   32'(ready_err),   32'd0);
        disp_read(10'd2, 10'd3, v, d);
        chk("clr_readback", 32'(d), 32'd0);

        // reset in the middle of a clear, with a display read in flight
        found = 0; armed = 0;
        @(negedge Clk);
        Clear_Start = 1'b1;
        for (int j = 0; j < 300 && found == 0; j++) begin
            @(negedge Clk);
            Clear_Start = 1'b0; Disp_Req = 1'b0;
            if (Mem_WE && Mem_Address == 8'd99 && armed == 0) begin
                Disp_Req = 1'b1; Disp_Row = 10'd1; Disp_Col = 10'd1; armed = 1;
            end else if (Mem_WE && Mem_Address == 8'd100) begin
                Reset_n = 1'b0; found = 1;
            end
        end
        Disp_Req = 1'b0;
        chk("abort_found", 32'(found), 32'd1);
        @(negedge Clk);
        chk("abort_busy",  32'(Busy),       32'd0);
        chk("abort_we",    32'(Mem_WE),     32'd0);
        chk("abort_dval",  32'(Disp_Valid), 32'd0);
        chk("abort_ready", 32'(Load_Ready), 32'd0);
        $display("clear aborted at write 100, busy=%0b", Busy);
        Reset_n = 1'b1;
        done_pulses = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Clear_Done) done_pulses++;
        end
        chk("abort_no_done", 32'(done_pulses), 32'd0);
        chk("abort_idle", 32'(Busy), 32'd0);

        // restart with a simultaneous load
        @(negedge Clk);
        Clear_Start = 1'b1;
        Load_Valid = 1'b1; Load_Row = 10'd3; Load_Col = 10'd3; Load_Data = 8'h77;
        #1 chk("restart_ready", 32'(Load_Ready), 32'd1);
        @(negedge Clk);
        Clear_Start = 1'b0; Load_Valid = 1'b0;
        chk("restart_load_we",   32'(Mem_WE),      32'd1);
        chk("restart_load_addr", 32'(Mem_Address), 32'd51);
        chk("restart_load_data", 32'(Mem_WData),   32'h77);
        chk("restart_busy",      32'(Busy),        32'd1);
        @(negedge Clk);
        chk("restart_we",    32'(Mem_WE),      32'd1);
        chk("restart_addr",  32'(Mem_Address), 32'd0);
        chk("restart_wdata", 32'(Mem_WData),   32'd0);
        $display("clear restarted at addr=%0d", Mem_Address);
        found = 0;
        for (int j = 0; j < 400 && found == 0; j++) begin
            @(negedge Clk);
            if (Clear_Done) found = 1;
        end
        chk("restart_done", 32'(found), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sprite_memory_arbiter.md
# vga_sprite_memory_arbiter

Sequencing controller for the single-port sprite memory. It shares the memory between the VGA display fetch path, a sprite loader and a built-in clear engine. It computes the linear sprite address as Row*Size + Col for each access and drives the synchronous RAM's address, write-enable and write-data pins. It sits between the VGA timing/pixel pipeline and the sprite RAM.

## Interface
- N, 8, memory address width; Size*Size <= 2^N is required
- Size, 16, sprite edge length in pixels (sprite is Size x Size)
- W, 8, pixel data width
- Clk  in  1  single clock; all state updates on its rising edge
- Reset_n  in  1  reset, synchronous, active-low
- Disp_Req  in  1  display wants the pixel at Disp_Row/Disp_Col this cycle
- Disp_Row, Disp_Col  in  10 each  sprite-local pixel coordinates
- Disp_Valid  out  1  Disp_Data holds the result of an earlier request
- Disp_Data  out  W  fetched pixel; 0 (transparent) for out-of-range coordinates
- Load_Valid  in  1  loader offers a write
- Load_Ready  out  1  write slot granted this cycle
- Load_Row, Load_Col  in  10 each  loader pixel coordinates
- Load_Data  in  W  loader pixel value
- Clear_Start  in  1  single-cycle pulse; zero the whole sprite
- Busy  out  1  clear in progress
- Clear_Done  out  1  one-cycle pulse after the last clear write
- Mem_Address  out  N  registered RAM address
- Mem_WE  out  1  registered RAM write enable
- Mem_WData  out  W  registered RAM write data
- Mem_RData  in  W  RAM read data; valid one cycle after the address is presented (synchronous read)

## Operation
- Address rule: Row*Size + Col, computed at full width, then truncated to N bits.
  - In range means Row < Size and Col < Size.
- FSM states: IDLE, CLEAR.
- Priority each cycle: display > clear > loader. The display is never stalled.
- Display access:
  - Disp_Req=1 issues a read (Mem_WE=0) at the display address.
  - If the coordinates are out of range, no RAM read is issued. The pipeline still returns Disp_Data=0 at the normal latency.
- Loader access:
  - Load_Ready = Reset_n & ~Disp_Req & (state==IDLE), combinational.
  - The transfer occurs on a clock edge where Load_Valid & Load_Ready.
  - An in-range transfer issues a write of Load_Data.
  - An out-of-range transfer is accepted and dropped (no write).
- Clear:
  - Clear_Start in IDLE loads the N+1-bit counter with 0 and enters CLEAR. Busy=1.
  - Each CLEAR cycle with Disp_Req=0 writes 0 to the address held in the counter, then increments the counter.
  - Cycles with Disp_Req=1 serve the display; the counter holds.
  - After the write to address Size*Size-1: return to IDLE, pulse Clear_Done for one cycle, Busy=0.
  - Clear_Start while in CLEAR is ignored.
- Idle cycles (no grant): Mem_WE=0. Mem_Address and Mem_WData hold their last values.

## Timing
- Reset, with Reset_n sampled low:
  - state=IDLE, counter=0.
  - Mem_Address=0, Mem_WE=0, Mem_WData=0.
  - Disp_Valid=0, Disp_Data=0.
  - Busy=0, Clear_Done=0, Load_Ready=0.
- Reset during CLEAR aborts the clear. No Clear_Done pulse; the in-flight display pipeline is flushed (Disp_Valid=0).
- Display latency:
  - A request sampled at edge E0 drives Mem_Address at E0.
  - The RAM returns data at E1.
  - Disp_Data/Disp_Valid are registered at E2.
  - Disp_Valid is therefore high in the cycle following E2, i.e. 3 edges after the request.
  - The path is fully pipelined: back-to-back requests give back-to-back Disp_Valid, in order.
- Load and clear writes appear on Mem_* in the cycle after the granting edge, with Mem_WE=1 for exactly one cycle.
- Clear duration: Size*Size write cycles plus the number of display-stolen cycles.
  - Clear_Done is asserted in the cycle after the final write edge.
- Simultaneous events:
  - Disp_Req with Load_Valid: display served, Load_Ready=0, loader waits. Load_* must hold stable until the handshake completes.
  - Clear_Start with Load_Valid in IDLE: the load completes in that cycle, and CLEAR begins next cycle.

## Test plan
- After reset, stream Disp_Req for (Row 0..15, Col 5): Mem_Address = 5, 21, ... 245; Disp_Valid high exactly 3 edges after each request; Disp_Data equals the RAM contents.
- Load Row=2, Col=3, Data=0xA5 with Disp_Req=0: Load_Ready=1, next cycle Mem_WE=1, Mem_Address=35, Mem_WData=0xA5; a later display read of (2,3) returns 0xA5.
- Hold Load_Valid while Disp_Req=1 for 4 cycles: Load_Ready=0 throughout and no write; the write occurs in the first cycle after Disp_Req falls.
- Out-of-range access: display (16,0) gives Disp_Data=0 with Disp_Valid at normal latency and no RAM read; loader (0,20) completes the handshake with Mem_WE never asserted.
- Clear_Start with 10 interleaved Disp_Req cycles: 256 zero writes to addresses 0..255 in order; Busy for 266 cycles; one Clear_Done pulse; Load_Ready=0 throughout.
- Drop Reset_n at clear write 100: next cycle state IDLE, Busy=0, Mem_WE=0, no Clear_Done pulse; a new Clear_Start restarts from address 0.
